// File: rtl/lsb_param_if.sv
// Memory request channel between the load/store buffer and the memory controller.
interface lsb_param_if #(
    parameter int XLEN  = 32,
    parameter int ROB_W = 3
);
    logic             mem_req_valid;
    logic             mem_req_ready;
    logic             mem_req_we;
    logic [2:0]       mem_req_funct3;
    logic [XLEN-1:0]  mem_req_addr;
    logic [XLEN-1:0]  mem_req_wdata;
    logic [ROB_W-1:0] mem_req_id;

    modport master (
        output mem_req_valid, mem_req_we, mem_req_funct3, mem_req_addr,
               mem_req_wdata, mem_req_id,
        input  mem_req_ready
    );

    modport slave (
        input  mem_req_valid, mem_req_we, mem_req_funct3, mem_req_addr,
               mem_req_wdata, mem_req_id,
        output mem_req_ready
    );
endinterface

// File: rtl/lsb_param.sv
// In-order load/store buffer: CDB operand snoop, commit-gated stores, flush recovery.
// Optional misalignment exceptions are enabled by defining LSB_MISALIGN_EN.
module lsb_param #(
    parameter int DEPTH_W = 3,
    parameter int XLEN    = 32,
    parameter int ROB_W   = 3,
    parameter int NUM_CDB = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     stall,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0] cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]  cdb_data,
    input  logic                     disp_valid,
    input  logic                     disp_is_store,
    input  logic [2:0]               disp_funct3,
    input  logic [ROB_W-1:0]         disp_rob_id,
    input  logic [XLEN-1:0]          disp_imm,
    input  logic                     disp_q1_pend,
    input  logic [ROB_W-1:0]         disp_q1,
    input  logic [XLEN-1:0]          disp_v1,
    input  logic                     disp_q2_pend,
    input  logic [ROB_W-1:0]         disp_q2,
    input  logic [XLEN-1:0]          disp_v2,
    output logic                     lsb_full,
    output logic                     lsb_empty,
    input  logic                     rob_commit_store,
    input  logic [ROB_W-1:0]         rob_commit_id,
    lsb_param_if.master              mem
`ifdef LSB_MISALIGN_EN
    ,
    output logic                     lsb_exc_valid,
    output logic [ROB_W-1:0]         lsb_exc_id
`endif
);
    localparam int DEPTH = 1 << DEPTH_W;
    localparam int CW    = DEPTH_W + 1;

    typedef logic [DEPTH_W-1:0] ptr_t;
    typedef struct packed {
        logic            hit;
        logic [XLEN-1:0] data;
    } snoop_t;

    // Lowest channel index wins when several carry the same tag.
    function automatic snoop_t snoop(input logic [ROB_W-1:0] tag);
        snoop_t s = '0;
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (cdb_valid[c] && cdb_tag[c*ROB_W +: ROB_W] == tag) begin
                s.hit  = 1'b1;
                s.data = cdb_data[c*XLEN +: XLEN];
            end
        end
        return s;
    endfunction

`ifdef LSB_MISALIGN_EN
    function automatic logic misaligned(input logic [2:0] f3, input logic [XLEN-1:0] a);
        return (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
    endfunction
`endif

    logic [DEPTH-1:0] busy, is_store, q1_pend, q2_pend, committed;
    logic [2:0]       funct3 [DEPTH];
    logic [ROB_W-1:0] rob_id [DEPTH];
    logic [ROB_W-1:0] q1     [DEPTH];
    logic [ROB_W-1:0] q2     [DEPTH];
    logic [XLEN-1:0]  v1     [DEPTH];
    logic [XLEN-1:0]  v2     [DEPTH];

    ptr_t          head, tail, cidx;
    logic [CW-1:0] count, ccount, ccount_nxt;
    logic          do_disp, slot_free, head_ok, mis, do_issue, do_exc, do_deq, deq_commit;
    snoop_t        d1, d2;
    snoop_t        s1 [DEPTH];
    snoop_t        s2 [DEPTH];

    assign lsb_full  = (count == CW'(DEPTH));
    assign lsb_empty = (count == '0);

    always_comb begin
        do_disp   = disp_valid && !stall && !lsb_full && !flush;
        cidx      = head + ptr_t'(ccount);
        slot_free = !mem.mem_req_valid || mem.mem_req_ready;
        head_ok   = busy[head] && !q1_pend[head] &&
                    (!is_store[head] || (!q2_pend[head] && committed[head]));
        mis       = 1'b0;
`ifdef LSB_MISALIGN_EN
        mis       = busy[head] && !q1_pend[head] && misaligned(funct3[head], v1[head]);
`endif
        do_issue   = !flush && slot_free && head_ok && !mis;
        do_exc     = !flush && slot_free && mis;
        do_deq     = do_issue || do_exc;
        deq_commit = do_deq && committed[head];
        ccount_nxt = ccount + CW'(rob_commit_store) - CW'(deq_commit);
        d1 = snoop(disp_q1);
        d2 = snoop(disp_q2);
        for (int i = 0; i < DEPTH; i++) begin
            s1[i] = snoop(q1[i]);
            s2[i] = snoop(q2[i]);
        end
    end

    // Control state: pointers, entry flags and the request slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0; tail <= '0; count <= '0; ccount <= '0;
            busy <= '0; committed <= '0; q1_pend <= '0; q2_pend <= '0;
            mem.mem_req_valid  <= 1'b0;
            mem.mem_req_we     <= 1'b0;
            mem.mem_req_funct3 <= '0;
            mem.mem_req_addr   <= '0;
            mem.mem_req_wdata  <= '0;
            mem.mem_req_id     <= '0;
`ifdef LSB_MISALIGN_EN
            lsb_exc_valid <= 1'b0;
            lsb_exc_id    <= '0;
`endif
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (q1_pend[i] && s1[i].hit) q1_pend[i] <= 1'b0;
                if (q2_pend[i] && s2[i].hit) q2_pend[i] <= 1'b0;
            end
            if (rob_commit_store) committed[cidx] <= 1'b1;
            if (do_deq) begin
                busy[head]      <= 1'b0;
                committed[head] <= 1'b0;
                head            <= head + 1'b1;
            end
            if (do_disp) begin
                busy[tail]      <= 1'b1;
                committed[tail] <= 1'b0;
                q1_pend[tail]   <= disp_q1_pend && !d1.hit;
                q2_pend[tail]   <= disp_is_store && disp_q2_pend && !d2.hit;
            end
            ccount <= ccount_nxt;
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!committed[i] && !(rob_commit_store && cidx == ptr_t'(i)))
                        busy[i] <= 1'b0;
                end
                tail  <= head + ptr_t'(ccount_nxt);
                count <= ccount_nxt;
            end else begin
                tail  <= tail + ptr_t'(do_disp);
                count <= count + CW'(do_disp) - CW'(do_deq);
            end

            if (do_issue) begin
                mem.mem_req_valid  <= 1'b1;
                mem.mem_req_we     <= is_store[head];
                mem.mem_req_funct3 <= funct3[head];
                mem.mem_req_addr   <= v1[head];
                mem.mem_req_wdata  <= v2[head];
                mem.mem_req_id     <= rob_id[head];
            end else if (flush && !mem.mem_req_we) begin
                mem.mem_req_valid <= 1'b0;
            end else if (mem.mem_req_ready) begin
                mem.mem_req_valid <= 1'b0;
            end
`ifdef LSB_MISALIGN_EN
            lsb_exc_valid <= do_exc;
            if (do_exc) lsb_exc_id <= rob_id[head];
`endif
        end
    end

    // Entry payload: address accumulates base + imm, store data captured on broadcast.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (q1_pend[i] && s1[i].hit) v1[i] <= v1[i] + s1[i].data;
            if (q2_pend[i] && s2[i].hit) v2[i] <= s2[i].data;
        end
        if (do_disp) begin
            is_store[tail] <= disp_is_store;
            funct3[tail]   <= disp_funct3;
            rob_id[tail]   <= disp_rob_id;
            q1[tail]       <= disp_q1;
            q2[tail]       <= disp_q2;
            v1[tail]       <= !disp_q1_pend ? disp_v1 + disp_imm :
                              d1.hit ? disp_imm + d1.data : disp_imm;
            v2[tail]       <= (disp_q2_pend && d2.hit) ? d2.data : disp_v2;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && rob_commit_store)
            assert (busy[cidx] && !committed[cidx] && rob_id[cidx] == rob_commit_id)
            else $error("lsb_param: commit does not match oldest uncommitted entry");
    end
`endif
endmodule
